stream_aligner: RTL and testbench
=================================

# stream_aligner

Packs a stream of variable-length byte chunks from the compression/decompression datapath into fixed-width output words, with valid/ready handshakes on both sides. It supports end-of-stream flush, so the final partial word is emitted with its byte count. It sits between the encoder/decoder byte emitter and the output word FIFO. It generalises the earlier fixed-width aligner with parametrised widths, backpressure, and a deeper carry buffer.

## Interface
- IN_BYTES, 34, maximum bytes per input chunk
- OUT_BYTES, 32, bytes per output word
- LEN_WIDTH, 6, width of in_len; must hold IN_BYTES
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  chunk present
- in_ready  out  1  chunk accepted when in_valid && in_ready
- in_data  in  IN_BYTES*8  chunk; byte k at bits [8k+7:8k]
- in_len  in  LEN_WIDTH  valid bytes in in_data (low bytes)
- in_last  in  1  chunk ends the stream
- out_valid  out  1  word present
- out_ready  in  1  word consumed when out_valid && out_ready
- out_data  out  OUT_BYTES*8  packed word; byte 0 is the oldest
- out_bytes  out  clog2(OUT_BYTES+1)  valid bytes in out_data
- out_last  out  1  final word of the stream
- stat_words, stat_bytes  out  32 each  only with STREAM_ALIGNER_STATS_EN

## Operation
- **Carry buffer:** BUF_BYTES = 2*OUT_BYTES + IN_BYTES, plus `fill` (byte count) and `state` registers.
- **Push:** new bytes are appended above the existing bytes, i.e. `buf |= in_data << (fill_after_pop*8)`.
  - in_len > IN_BYTES is clamped to IN_BYTES.
  - in_len = 0 without in_last is accepted and changes nothing.
- **Pop:** `buf >>= OUT_BYTES*8`, then `fill -= OUT_BYTES`, saturating at 0 for a partial last word.
- **Same-cycle push and pop:** the pop is applied first, then the push at the reduced offset.
- **States:**
  - FILL
    - in_ready = (fill <= 2*OUT_BYTES).
    - out_valid = (fill >= OUT_BYTES).
    - Accepting in_last moves to DRAIN.
  - DRAIN
    - in_ready = 0.
    - out_valid = (fill > 0), or a single zero-length word if fill = 0 on entry.
    - out_last = 1 on the word that leaves fill = 0.
    - That word's pop returns to FILL.
- **Output fields:**
  - out_bytes = OUT_BYTES on full words; the residual count on the last word.
  - Bytes above out_bytes are driven to zero.
- **Empty stream:** in_last with fill = 0 and in_len = 0 produces exactly one word with out_valid=1, out_bytes=0, out_last=1.
- **Reset:** all outputs take their reset values on the first clock with reset low, regardless of state.
  - Partial data is discarded and stats are cleared.
  - Reset values: in_ready=0, out_valid=0, out_last=0, out_bytes=0, out_data=0, fill=0, state FILL.

## Timing
- All outputs are functions of registers only; there is no combinational path from any input to any output.
- **Latency:** a chunk accepted at edge N can appear in out_data from cycle N+1.
- **Throughput:** one chunk per cycle while the average in_len ≤ OUT_BYTES and out_ready=1.
- **Output stability:** out_data, out_bytes and out_last are held stable while out_valid && !out_ready.
- **Input protocol:** the source must hold in_data, in_len and in_last until accepted.
- **in_ready:** first asserts on the cycle after reset is released.

## Configuration
- **STREAM_ALIGNER_STATS_EN defined:**
  - stat_words counts output handshakes.
  - stat_bytes accumulates out_bytes on each output handshake.
  - Both are 32-bit, saturate at 2^32-1, and clear on reset.
- **STREAM_ALIGNER_STATS_EN undefined:** the stat ports and counters are absent; datapath behaviour is identical.

## Structure
- **Shared package `aligner_pkg`:**
  - state enum {FILL, DRAIN}
  - BUF_BYTES derivation
  - clog2-based width constants for fill and out_bytes
- **Sub-module `aligner_byte_shifter`:** combinational byte-granular left/right shifter over BUF_BYTES.
  - Instantiated twice: once for pop, once for push placement.
- **Control:** fill arithmetic and FSM stay in the top level.

## Test plan
All scenarios use OUT_BYTES=32 and IN_BYTES=34.
- **Fixed-length stream:** 16 chunks with in_len=8 and incrementing byte pattern, then in_last on chunk 17 (len 8), out_ready=1.
  - Expect 4 full words plus 1 word with out_bytes=8 and out_last=1.
  - Bytes must come out in order.
- **Max-length chunks:** chunks with in_len=34, out_ready=1.
  - Expect in_ready to stay high and one output word per cycle after the first.
  - fill must never exceed 98.
- **Backpressure:** out_ready=0 for 10 cycles during a stream of len 34 chunks.
  - in_ready must drop when fill > 64.
  - out_data must be held stable.
  - No byte may be lost or duplicated after release.
- **Empty stream:** in_last with in_len=0 at fill=0.
  - Expect one word with out_bytes=0, out_last=1, out_data=0; then back in FILL with in_ready=1.
- **Reset mid-drain:** reset low for 1 cycle during DRAIN with fill=40.
  - Expect out_valid=0, in_ready=0 in that cycle.
  - A new stream afterwards must show no residual bytes.
- **Stats (with macro):** after the first scenario, expect stat_words=5 and stat_bytes=136.

Source files
------------

// File: rtl/aligner_pkg.sv
// Shared types and size helpers for stream_aligner and aligner_byte_shifter.
package aligner_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // The carry buffer holds two full output words plus one maximal chunk.
   function automatic int buf_bytes(input int in_bytes, input int out_bytes);
      return 2 * out_bytes + in_bytes;
   endfunction

   // Width of a counter that must represent 0..max_count inclusive.
   function automatic int count_width(input int max_count);
      return $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/aligner_byte_shifter.sv
// Combinational byte-granular shifter over the carry buffer; direction chosen per instance.
module aligner_byte_shifter
   import aligner_pkg::*;
#(
   parameter int BYTES     = buf_bytes(34, 32),
   parameter int AMT_WIDTH = count_width(buf_bytes(34, 32))
) (
   input  logic [BYTES*8-1:0]   data_in,
   input  logic [AMT_WIDTH-1:0] amount,
   input  logic                 shift_left,
   output logic [BYTES*8-1:0]   data_out
);

   logic [AMT_WIDTH+2:0] bit_amount;

   assign bit_amount = {amount, 3'b000};
   assign data_out   = shift_left ? (data_in << bit_amount) : (data_in >> bit_amount);

endmodule

// File: rtl/stream_aligner.sv
// Packs variable-length byte chunks into fixed-width words with end-of-stream flush.
// Optional statistics counters are built when STREAM_ALIGNER_STATS_EN is defined.
module stream_aligner
   import aligner_pkg::*;
#(
   parameter int IN_BYTES  = 34,
   parameter int OUT_BYTES = 32,
   parameter int LEN_WIDTH = 6
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [IN_BYTES*8-1:0]               in_data,
   input  logic [LEN_WIDTH-1:0]                in_len,
   input  logic                                in_last,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [OUT_BYTES*8-1:0]              out_data,
   output logic [count_width(OUT_BYTES)-1:0]   out_bytes,
   output logic                                out_last
`ifdef STREAM_ALIGNER_STATS_EN
   ,
   output logic [31:0]                         stat_words,
   output logic [31:0]                         stat_bytes
`endif
);

   localparam int BUF_BYTES = buf_bytes(IN_BYTES, OUT_BYTES);
   localparam int FILL_W    = count_width(BUF_BYTES);
   localparam int OB_W      = count_width(OUT_BYTES);

   localparam logic [FILL_W-1:0]    OUT_FILL     = FILL_W'(OUT_BYTES);
   localparam logic [FILL_W-1:0]    TWO_OUT_FILL = FILL_W'(2 * OUT_BYTES);
   localparam logic [LEN_WIDTH-1:0] IN_LEN_MAX   = LEN_WIDTH'(IN_BYTES);

   state_t                 state_q, state_d;
   logic                   active_q;
   logic [BUF_BYTES*8-1:0] buf_q, buf_d, popped, push_src, pushed;
   logic [FILL_W-1:0]      fill_q, fill_d, fill_after_pop, push_len, pop_amount;
   logic [LEN_WIDTH-1:0]   len_clamped;
   logic                   pop, push;

   // Every output derives from registers only; active_q holds in_ready low for the reset cycle.
   assign in_ready  = active_q && (state_q == FILL) && (fill_q <= TWO_OUT_FILL);
   assign out_valid = (state_q == DRAIN) || (fill_q >= OUT_FILL);
   assign out_last  = (state_q == DRAIN) && (fill_q <= OUT_FILL);
   assign out_bytes = !out_valid          ? '0 :
                      (fill_q >= OUT_FILL) ? OB_W'(OUT_BYTES) : fill_q[OB_W-1:0];
   assign out_data  = out_valid ? buf_q[OUT_BYTES*8-1:0] : '0;

   assign pop  = out_valid && out_ready;
   assign push = in_valid && in_ready;

   assign len_clamped    = (in_len > IN_LEN_MAX) ? IN_LEN_MAX : in_len;
   assign push_len       = push ? FILL_W'(len_clamped) : '0;
   assign pop_amount     = pop ? OUT_FILL : '0;
   assign fill_after_pop = !pop                ? fill_q :
                           (fill_q >= OUT_FILL) ? fill_q - OUT_FILL : '0;
   assign fill_d         = fill_after_pop + push_len;

   // Bytes beyond the chunk length are zeroed so the buffer stays clean above fill.
   always_comb begin
      // NOTE: default first so no path leaves push_src unassigned and infers a latch.
      push_src = '0;
      for (int k = 0; k < IN_BYTES; k++) begin
         if (push && (k < int'(len_clamped))) begin
            push_src[k*8 +: 8] = in_data[k*8 +: 8];
         end
      end
   end

   aligner_byte_shifter #(
      .BYTES     (BUF_BYTES),
      .AMT_WIDTH (FILL_W)
   ) u_pop_shift (
      .data_in    (buf_q),
      .amount     (pop_amount),
      .shift_left (1'b0),
      .data_out   (popped)
   );

   aligner_byte_shifter #(
      .BYTES     (BUF_BYTES),
      .AMT_WIDTH (FILL_W)
   ) u_push_shift (
      .data_in    (push_src),
      .amount     (fill_after_pop),
      .shift_left (1'b1),
      .data_out   (pushed)
   );

   assign buf_d = popped | pushed;

   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:    if (push && in_last) state_d = DRAIN;
         DRAIN:   if (pop && out_last) state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= FILL;
         active_q <= 1'b0;
         fill_q   <= '0;
         // NOTE: the buffer is reset, not just fill, because pushes OR into bytes assumed zero.
         buf_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register update on the same edge.
         state_q  <= state_d;
         active_q <= 1'b1;
         fill_q   <= fill_d;
         buf_q    <= buf_d;
      end
   end

`ifdef STREAM_ALIGNER_STATS_EN
   logic [32:0] bytes_sum;

   assign bytes_sum = {1'b0, stat_bytes} + 33'(out_bytes);

   always_ff @(posedge clk) begin
      if (!reset) begin
         stat_words <= '0;
         stat_bytes <= '0;
      end else if (pop) begin
         if (stat_words != '1) stat_words <= stat_words + 32'd1;
         stat_bytes <= bytes_sum[32] ? '1 : bytes_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_stream_aligner.sv
// Self-checking bench for stream_aligner: vector table, directed scenarios and random traffic.
module tb_stream_aligner;

   localparam int IN_BYTES  = 34;
   localparam int OUT_BYTES = 32;
   localparam int LEN_WIDTH = 6;
   localparam int BUF_BYTES = 2 * OUT_BYTES + IN_BYTES;

   logic                   clk       = 1'b0;
   logic                   reset     = 1'b0;
   logic                   in_valid  = 1'b0;
   logic                   in_ready;
   logic [IN_BYTES*8-1:0]  in_data   = '0;
   logic [LEN_WIDTH-1:0]   in_len    = '0;
   logic                   in_last   = 1'b0;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [OUT_BYTES*8-1:0] out_data;
   logic [5:0]             out_bytes;
   logic                   out_last;
`ifdef STREAM_ALIGNER_STATS_EN
   logic [31:0]            stat_words;
   logic [31:0]            stat_bytes;
`endif

   always #5 clk = ~clk;

   stream_aligner #(
      .IN_BYTES  (IN_BYTES),
      .OUT_BYTES (OUT_BYTES),
      .LEN_WIDTH (LEN_WIDTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_len    (in_len),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_bytes (out_bytes),
      .out_last  (out_last)
`ifdef STREAM_ALIGNER_STATS_EN
      ,
      .stat_words (stat_words),
      .stat_bytes (stat_bytes)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // out_ready driver: fixed level or random, applied 2 time units after each edge.
   bit ready_force = 1'b0;
   bit rand_mode   = 1'b0;
   always @(posedge clk) begin
      #2;
      out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : ready_force;
   end

   // Reference model: the stream as a byte queue plus an end-of-stream flag.
   logic [7:0]   m_q[$];
   bit           m_last_seen = 1'b0;
   bit           m_active    = 1'b0;
   int           words_seen  = 0;
   int           last_words  = 0;
   bit           hold_prev   = 1'b0;
   logic [255:0] prev_data;
   logic [5:0]   prev_bytes;
   logic         prev_last;
   bit           e_valid, e_ready, e_last;
   int           e_n, clamp;
   logic [255:0] e_data;

   always @(negedge clk) begin
      e_ready = m_active && !m_last_seen && (m_q.size() <= 2 * OUT_BYTES);
      e_valid = m_last_seen || (m_q.size() >= OUT_BYTES);
      e_n     = !e_valid ? 0 : ((m_q.size() < OUT_BYTES) ? m_q.size() : OUT_BYTES);
      e_last  = e_valid && m_last_seen && (m_q.size() <= OUT_BYTES);
      e_data  = '0;
      for (int i = 0; i < e_n; i++) e_data[i*8 +: 8] = m_q[i];

      check("in_ready", in_ready, e_ready);
      check("out_valid", out_valid, e_valid);
      check("fill_bound", dut.fill_q <= BUF_BYTES, 1);
      if (e_valid) begin
         check("out_bytes", out_bytes, e_n);
         check("out_last", out_last, e_last);
         check("out_data", out_data, e_data);
      end
      if (hold_prev) begin
         check("hold_data", out_data, prev_data);
         check("hold_bytes", out_bytes, prev_bytes);
         check("hold_last", out_last, prev_last);
      end

      hold_prev  = reset && e_valid && !out_ready;
      prev_data  = out_data;
      prev_bytes = out_bytes;
      prev_last  = out_last;

      if (!reset) begin
         m_q.delete();
         m_last_seen = 1'b0;
         m_active    = 1'b0;
      end else begin
         if (e_valid && out_ready) begin
            words_seen++;
            if (e_last) begin
               last_words++;
               m_last_seen = 1'b0;
            end
            repeat (e_n) void'(m_q.pop_front());
         end
         if (in_valid && e_ready) begin
            clamp = (int'(in_len) > IN_BYTES) ? IN_BYTES : int'(in_len);
            for (int k = 0; k < clamp; k++) m_q.push_back(in_data[k*8 +: 8]);
            if (in_last) m_last_seen = 1'b1;
         end
         m_active = 1'b1;
      end
   end

   logic [7:0] seq = 8'd0;
   int         last_wait;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_chunk(input int len, input bit last);
      in_len  = LEN_WIDTH'(len);
      in_last = last;
      for (int k = 0; k < IN_BYTES; k++) begin
         if (k < len) begin
            in_data[k*8 +: 8] = seq;
            seq = seq + 8'd1;
         end else begin
            in_data[k*8 +: 8] = 8'($urandom);
         end
      end
   endtask

   task automatic send(input int len, input bit last);
      int waited = 0;
      in_valid = 1'b1;
      load_chunk(len, last);
      while (!in_ready && waited < 300) begin
         tick();
         waited++;
      end
      if (!in_ready) check("send_timeout", 0, 1);
      else tick();
      last_wait = waited;
      in_valid  = 1'b0;
      in_last   = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int c = 0;
      while ((m_q.size() != 0 || m_last_seen) && c < 500) begin
         tick();
         c++;
      end
      check(name, (m_q.size() == 0) && !m_last_seen, 1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   typedef struct {
      bit rst_n;
      bit valid;
      int len;
      bit last;
      bit ready;
      bit e_in_ready;
      bit e_out_valid;
      int e_bytes;
      bit e_last;
   } vec_t;

   vec_t vecs[14];
   int   w0, l0;

   initial begin
      //          rst valid len last rdy | in_rdy out_v bytes last
      vecs[0]  = '{0, 0,  0, 0, 0,  0, 0,  0, 0};
      vecs[1]  = '{1, 0,  0, 0, 1,  1, 0,  0, 0};
      vecs[2]  = '{1, 1, 20, 0, 1,  1, 0,  0, 0};
      vecs[3]  = '{1, 1, 20, 0, 1,  1, 1, 32, 0};
      vecs[4]  = '{1, 1,  0, 0, 0,  1, 1, 32, 0};
      vecs[5]  = '{1, 1, 34, 0, 0,  0, 1, 32, 0};
      vecs[6]  = '{1, 0,  0, 0, 1,  1, 1, 32, 0};
      vecs[7]  = '{1, 1, 10, 1, 1,  0, 1, 20, 1};
      vecs[8]  = '{1, 0,  0, 0, 0,  0, 1, 20, 1};
      vecs[9]  = '{1, 0,  0, 0, 1,  1, 0,  0, 0};
      vecs[10] = '{1, 1,  0, 1, 0,  0, 1,  0, 1};
      vecs[11] = '{1, 0,  0, 0, 1,  1, 0,  0, 0};
      vecs[12] = '{1, 1, 40, 0, 1,  1, 1, 32, 0};
      vecs[13] = '{1, 0,  0, 0, 1,  1, 0,  0, 0};

      tick();
      foreach (vecs[i]) begin
         reset       = vecs[i].rst_n;
         in_valid    = vecs[i].valid;
         ready_force = vecs[i].ready;
         load_chunk(vecs[i].len, vecs[i].last);
         tick();
         in_valid = 1'b0;
         in_last  = 1'b0;
         check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_in_ready);
         check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_out_valid);
         if (vecs[i].e_out_valid || !vecs[i].rst_n) begin
            check($sformatf("vec%0d_out_bytes", i), out_bytes, vecs[i].e_bytes);
            check($sformatf("vec%0d_out_last", i), out_last, vecs[i].e_last);
         end
         if (!vecs[i].rst_n) check("vec0_out_data", out_data, 0);
      end

      // Fixed-length stream: 17 chunks of 8 bytes.
      do_reset();
      ready_force = 1'b1;
      w0 = words_seen;
      l0 = last_words;
      for (int i = 0; i < 16; i++) send(8, 1'b0);
      send(8, 1'b1);
      wait_idle("fixed_idle");
      check("fixed_words", words_seen - w0, 5);
      check("fixed_last_words", last_words - l0, 1);
`ifdef STREAM_ALIGNER_STATS_EN
      check("stat_words", stat_words, 5);
      check("stat_bytes", stat_bytes, 136);
`endif

      // Maximum-length chunks back to back.
      do_reset();
      ready_force = 1'b1;
      w0 = words_seen;
      for (int i = 0; i < 12; i++) begin
         send(34, 1'b0);
         check("maxlen_no_stall", last_wait, 0);
      end
      check("maxlen_words", words_seen - w0, 11);
      send(0, 1'b1);
      wait_idle("maxlen_idle");

      // Backpressure: out_ready low for 10 cycles during len-34 chunks.
      do_reset();
      ready_force = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(34, 1'b0);
            send(0, 1'b1);
         end
         begin
            repeat (4) @(posedge clk);
            #3;
            check("bp_in_ready_low", in_ready, 0);
            repeat (6) @(posedge clk);
            #1;
            ready_force = 1'b1;
         end
      join
      wait_idle("bp_idle");

      // Reset in the middle of a drain holding 40 bytes.
      do_reset();
      ready_force = 1'b0;
      send(34, 1'b0);
      send(6, 1'b1);
      check("drain_valid", out_valid, 1);
      check("drain_bytes", out_bytes, 32);
      check("drain_in_ready", in_ready, 0);
      reset = 1'b0;
      tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_last", out_last, 0);
      reset       = 1'b1;
      ready_force = 1'b1;
      tick();
      send(10, 1'b1);
      wait_idle("post_reset_idle");

      // Random lengths, random end-of-stream and random backpressure.
      do_reset();
      rand_mode = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send($urandom_range(0, 40), $urandom_range(0, 15) == 0);
      end
      send(5, 1'b1);
      wait_idle("rand_idle");
      rand_mode = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
